// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - shared state type and masked compare for the sequence detector
package seq_det_pkg;

    typedef enum logic [0:0] {
        FILL  = 1'b0,
        ARMED = 1'b1
    } seq_det_state_t;

    // Widest pattern the compare helper handles; callers zero-extend.
    localparam int MAX_N = 32;

    function automatic logic masked_eq(
        input logic [MAX_N-1:0] pattern,
        input logic [MAX_N-1:0] mask,
        input logic [MAX_N-1:0] window
    );
        return ((pattern ^ window) & ~mask) == '0;
    endfunction

endpackage

// File: rtl/seq_det_sat_counter.sv
// rtl/seq_det_sat_counter.sv - saturating match counter with registered all-ones flag
module seq_det_sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             sat
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
            sat <= 1'b0;
        end else if (inc && (cnt != CNT_MAX)) begin
            cnt <= cnt + 1'b1;
            sat <= ((cnt + 1'b1) == CNT_MAX);
        end
    end

endmodule

// File: rtl/detect_sequence_param_fsm.sv
// rtl/detect_sequence_param_fsm.sv - runtime-programmable serial sequence detector
// Optional don't-care mask enabled by defining SEQ_DET_MASK_EN.
module detect_sequence_param_fsm
    import seq_det_pkg::*;
#(
    parameter int             N           = 6,
    parameter logic [N-1:0]   DEF_PATTERN = 6'b110011,
    parameter int             CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a,
    input  logic             a_valid,
    input  logic             cfg_valid,
    input  logic [N-1:0]     cfg_pattern,
    input  logic [N-1:0]     cfg_mask,
    input  logic             overlap,
    output logic             detected,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat
);

    localparam int FILL_W = $clog2(N + 1);
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(N - 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(N);

    seq_det_state_t    state;
    logic [N-1:0]      pattern_q;
    logic [N-1:0]      mask_q;
    logic [N-1:0]      history;
    logic [FILL_W-1:0] fill;
    logic [N-1:0]      window;
    logic              window_full;
    logic              match;

`ifdef SEQ_DET_MASK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            mask_q <= '0;
        end else if (cfg_valid) begin
            mask_q <= cfg_mask;
        end
    end
`else
    logic unused_cfg_mask;
    assign unused_cfg_mask = ^cfg_mask;
    assign mask_q = '0;
`endif

    // The incoming bit completes the window when N-1 bits are already held.
    assign window      = {history[N-2:0], a};
    assign window_full = (state == ARMED) || (fill == FILL_LAST);
    assign match       = a_valid && !cfg_valid && window_full &&
                         masked_eq(MAX_N'(pattern_q), MAX_N'(mask_q), MAX_N'(window));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FILL;
            pattern_q <= DEF_PATTERN;
            history   <= '0;
            fill      <= '0;
            detected  <= 1'b0;
        end else if (cfg_valid) begin
            state     <= FILL;
            pattern_q <= cfg_pattern;
            history   <= '0;
            fill      <= '0;
            detected  <= 1'b0;
        end else if (a_valid) begin
            history  <= window;
            detected <= match;
            if (match && !overlap) begin
                fill  <= '0;
                state <= FILL;
            end else begin
                if (fill != FILL_FULL) begin
                    fill <= fill + 1'b1;
                end
                if (window_full) begin
                    state <= ARMED;
                end
            end
        end else begin
            detected <= 1'b0;
        end
    end

    seq_det_sat_counter #(
        .CNT_W(CNT_W)
    ) u_counter (
        .clk (clk),
        .rst (rst),
        .inc (match),
        .clr (cfg_valid),
        .cnt (match_cnt),
        .sat (cnt_sat)
    );

endmodule

// File: tb/tb_detect_sequence_param_fsm.sv
// tb/tb_detect_sequence_param_fsm.sv - randomized self-checking bench for detect_sequence_param_fsm
`timescale 1ns/1ps
module tb_detect_sequence_param_fsm;

    localparam int N = 6;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         a = 1'b0;
    logic         a_valid = 1'b0;
    logic         cfg_valid = 1'b0;
    logic [N-1:0] cfg_pattern = '0;
    logic [N-1:0] cfg_mask = '0;
    logic         overlap = 1'b1;

    logic         det0;
    logic [7:0]   cnt0;
    logic         sat0;
    logic         det1;
    logic [1:0]   cnt1;
    logic         sat1;

    int checks = 0;
    int errors = 0;
    int det_seen = 0;

    detect_sequence_param_fsm #(.N(N), .DEF_PATTERN(6'b110011), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .a(a), .a_valid(a_valid), .cfg_valid(cfg_valid),
        .cfg_pattern(cfg_pattern), .cfg_mask(cfg_mask), .overlap(overlap),
        .detected(det0), .match_cnt(cnt0), .cnt_sat(sat0)
    );

    detect_sequence_param_fsm #(.N(N), .DEF_PATTERN(6'b111111), .CNT_W(2)) dut_small (
        .clk(clk), .rst(rst), .a(a), .a_valid(a_valid), .cfg_valid(cfg_valid),
        .cfg_pattern(cfg_pattern), .cfg_mask(cfg_mask), .overlap(overlap),
        .detected(det1), .match_cnt(cnt1), .cnt_sat(sat1)
    );

    always #5 clk = ~clk;

    // Reference model: per instance, the list of fresh bits since the last clear.
    logic [N-1:0] m_def [2] = '{6'b110011, 6'b111111};
    int           m_max [2] = '{255, 3};
    logic [N-1:0] m_pat [2];
    logic [N-1:0] m_mask;
    bit           m_q   [2][$];
    bit           m_det [2];
    int           m_cnt [2];

    function automatic bit tail_matches(int i);
        int base;
        base = m_q[i].size() - N;
        for (int k = 0; k < N; k++) begin
            if (!m_mask[N-1-k] && (m_q[i][base + k] != m_pat[i][N-1-k])) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            m_det[i] = 1'b0;
            if (rst) begin
                m_pat[i] = m_def[i];
                m_q[i].delete();
                m_cnt[i] = 0;
            end else if (cfg_valid) begin
                m_pat[i] = cfg_pattern;
                m_q[i].delete();
                m_cnt[i] = 0;
            end else if (a_valid) begin
                m_q[i].push_back(a);
                if (m_q[i].size() >= N && tail_matches(i)) begin
                    m_det[i] = 1'b1;
                    if (m_cnt[i] < m_max[i]) m_cnt[i]++;
                    if (!overlap) m_q[i].delete();
                end
                while (m_q[i].size() > N) void'(m_q[i].pop_front());
            end
        end
        if (rst) m_mask = '0;
`ifdef SEQ_DET_MASK_EN
        else if (cfg_valid) m_mask = cfg_mask;
`endif
    endtask

    task automatic step(input logic r, input logic bit_a, input logic av,
                        input logic cv, input logic [N-1:0] cp, input logic [N-1:0] cm,
                        input logic ov);
        @(negedge clk);
        rst = r; a = bit_a; a_valid = av; cfg_valid = cv;
        cfg_pattern = cp; cfg_mask = cm; overlap = ov;
        @(posedge clk);
        model_edge();
        #1;
        checks++;
        if (det0 !== m_det[0]) begin
            errors++; $display("FAIL detected0 got %b expected %b at %0t", det0, m_det[0], $time);
        end
        checks++;
        if (cnt0 !== 8'(m_cnt[0])) begin
            errors++; $display("FAIL match_cnt0 got %0d expected %0d at %0t", cnt0, m_cnt[0], $time);
        end
        checks++;
        if (sat0 !== (m_cnt[0] == m_max[0])) begin
            errors++; $display("FAIL cnt_sat0 got %b expected %b at %0t", sat0, m_cnt[0] == m_max[0], $time);
        end
        checks++;
        if (det1 !== m_det[1]) begin
            errors++; $display("FAIL detected1 got %b expected %b at %0t", det1, m_det[1], $time);
        end
        checks++;
        if (cnt1 !== 2'(m_cnt[1])) begin
            errors++; $display("FAIL match_cnt1 got %0d expected %0d at %0t", cnt1, m_cnt[1], $time);
        end
        checks++;
        if (sat1 !== (m_cnt[1] == m_max[1])) begin
            errors++; $display("FAIL cnt_sat1 got %b expected %b at %0t", sat1, m_cnt[1] == m_max[1], $time);
        end
        det_seen += int'(det0);
    endtask

    task automatic bit_in(input logic b, input logic ov);
        step(1'b0, b, 1'b1, 1'b0, '0, '0, ov);
    endtask

    task automatic send(input logic [7:0] bits, input int len, input logic ov);
        for (int k = len - 1; k >= 0; k--) bit_in(bits[k], ov);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1, 6'b101010, 6'b111111, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (det0 !== 1'b0 || cnt0 !== 8'd0 || sat0 !== 1'b0) begin
            errors++; $display("FAIL reset_state got det=%b cnt=%0d sat=%b expected 0/0/0", det0, cnt0, sat0);
        end
    endtask

    task automatic test_basic();
        do_reset();
        det_seen = 0;
        send(8'b00110011, 6, 1'b1);
        checks++;
        if (det_seen != 1 || cnt0 !== 8'd1) begin
            errors++; $display("FAIL basic_match got pulses=%0d cnt=%0d expected 1/1", det_seen, cnt0);
        end
    endtask

    task automatic test_overlap();
        step(1'b0, 1'b0, 1'b0, 1'b1, 6'b101010, '0, 1'b1);
        det_seen = 0;
        send(8'b10101010, 8, 1'b1);
        checks++;
        if (det_seen != 2 || cnt0 !== 8'd2) begin
            errors++; $display("FAIL overlap_on got pulses=%0d cnt=%0d expected 2/2", det_seen, cnt0);
        end
        step(1'b0, 1'b0, 1'b0, 1'b1, 6'b101010, '0, 1'b0);
        det_seen = 0;
        send(8'b10101010, 8, 1'b0);
        checks++;
        if (det_seen != 1 || cnt0 !== 8'd1) begin
            errors++; $display("FAIL overlap_off got pulses=%0d cnt=%0d expected 1/1", det_seen, cnt0);
        end
    endtask

    task automatic test_gaps();
        logic [5:0] p;
        do_reset();
        det_seen = 0;
        p = 6'b110011;
        for (int k = N - 1; k >= 0; k--) begin
            int gap;
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) step(1'b0, $urandom_range(0, 1), 1'b0, 1'b0, '0, '0, 1'b1);
            bit_in(p[k], 1'b1);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
        checks++;
        if (det_seen != 1) begin
            errors++; $display("FAIL gapped_match got pulses=%0d expected 1", det_seen);
        end
    endtask

    task automatic test_cfg_collision();
        do_reset();
        det_seen = 0;
        send(8'b00011001, 5, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b1, 6'b000000, '0, 1'b1);
        checks++;
        if (det_seen != 0 || cnt0 !== 8'd0) begin
            errors++; $display("FAIL cfg_wins got pulses=%0d cnt=%0d expected 0/0", det_seen, cnt0);
        end
        send(8'b00000000, 6, 1'b1);
        checks++;
        if (det_seen != 1 || cnt0 !== 8'd1) begin
            errors++; $display("FAIL cfg_then_zeros got pulses=%0d cnt=%0d expected 1/1", det_seen, cnt0);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        send(8'hFF, 8, 1'b1);
        checks++;
        if (cnt1 !== 2'd3 || sat1 !== 1'b1) begin
            errors++; $display("FAIL sat_reach got cnt=%0d sat=%b expected 3/1", cnt1, sat1);
        end
        send(8'h0F, 4, 1'b1);
        checks++;
        if (cnt1 !== 2'd3 || sat1 !== 1'b1) begin
            errors++; $display("FAIL sat_hold got cnt=%0d sat=%b expected 3/1", cnt1, sat1);
        end
    endtask

    task automatic test_mask();
        int want;
        do_reset();
        step(1'b0, 1'b0, 1'b0, 1'b1, 6'b110010, 6'b000001, 1'b1);
        det_seen = 0;
        send(8'b00110011, 6, 1'b1);
`ifdef SEQ_DET_MASK_EN
        want = 1;
`else
        want = 0;
`endif
        checks++;
        if (det_seen != want) begin
            errors++; $display("FAIL mask_match got pulses=%0d expected %0d", det_seen, want);
        end
    endtask

    task automatic test_random();
        logic [N-1:0] pats [4] = '{6'b110011, 6'b111111, 6'b101010, 6'b000000};
        logic         ov;
        ov = 1'b1;
        do_reset();
        for (int t = 0; t < 2000; t++) begin
            logic r, cv;
            if ($urandom_range(0, 49) == 0) ov = ~ov;
            r  = ($urandom_range(0, 299) == 0);
            cv = ($urandom_range(0, 99) == 0);
            step(r, $urandom_range(0, 1), ($urandom_range(0, 3) != 0), cv,
                 pats[$urandom_range(0, 3)], N'($urandom_range(0, 3)), ov);
        end
    endtask

    initial begin
        m_mask = '0;
        for (int i = 0; i < 2; i++) begin
            m_pat[i] = m_def[i];
            m_cnt[i] = 0;
            m_det[i] = 1'b0;
        end
        test_reset();
        test_basic();
        test_overlap();
        test_gaps();
        test_cfg_collision();
        test_saturate();
        test_mask();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
